// File: rtl/synaptic_input_accumulator.sv
// Spike-event accumulator: buffers presynaptic events, sums their FP32
// weights and publishes one input current per closed timestep.
module Addition_Subtraction (
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        AddBar_Sub,
    output logic        Exception,
    output logic [31:0] result
);
    logic [31:0] bx, x, y;
    logic [7:0]  ex, ey, sh;
    logic [26:0] mx, my, myl, n;
    logic [27:0] s;
    logic [9:0]  e;
    logic [4:0]  lz;
    logic [24:0] r;
    logic [22:0] mant;
    logic        up;

    always_comb begin
        bx = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
        if (bx[30:0] > a_operand[30:0]) begin
            x = bx;
            y = a_operand;
        end else begin
            x = a_operand;
            y = bx;
        end
        ex = x[30:23];
        ey = y[30:23];
        sh = ex - ey;
        // subnormals are flushed to zero
        mx = (ex == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
        my = (ey == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
        if (sh > 8'd26)
            myl = {26'd0, |my};
        else
            myl = (my >> sh) | {26'd0, |(my & ~(27'h7FFFFFF << sh))};
        lz = 5'd0;
        if (x[31] == y[31])
            s = {1'b0, mx} + {1'b0, myl};
        else
            s = {1'b0, mx} - {1'b0, myl};
        if (s[27]) begin
            n = s[27:1] | {26'd0, s[0]};
            e = {2'd0, ex} + 10'd1;
        end else begin
            for (int i = 0; i < 27; i++)
                if (s[i]) lz = 5'(26 - i);
            n = s[26:0] << lz;
            e = {2'd0, ex} - {5'd0, lz};
        end
        up = n[2] & (n[3] | n[1] | n[0]);
        r = {1'b0, n[26:3]} + {24'd0, up};
        mant = r[24] ? r[23:1] : r[22:0];
        if (r[24]) e = e + 10'd1;
        Exception = 1'b0;
        result = {x[31], e[7:0], mant};
        if (ex == 8'hFF) begin
            result = x;
            Exception = 1'b1;
        end else if (s == 28'd0) begin
            result = 32'd0;
        end else if (!e[9] && e >= 10'd255) begin
            result = {x[31], 8'hFF, 23'd0};
            Exception = 1'b1;
        end else if (e[9] || e == 10'd0) begin
            result = {x[31], 31'd0};
        end
    end
endmodule

module synaptic_input_accumulator #(
    parameter int NUM_SYN    = 16,
    parameter int IDX_W      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_we,
    input  logic [IDX_W-1:0] w_addr,
    input  logic [31:0]      w_data,
    input  logic             spike_valid,
    input  logic [IDX_W-1:0] spike_idx,
    output logic             spike_ready,
    input  logic             close_step,
    output logic [31:0]      current_out,
    output logic             current_valid,
    output logic             busy,
    output logic [15:0]      event_count,
    output logic             acc_exc
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, POP, ACC, DRAIN, PUBLISH} state_t;

    state_t           state_q;
    logic [31:0]      w_q    [NUM_SYN];
    logic [IDX_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PW:0]      wr_q, rd_q;
    logic [31:0]      acc_q, op_q, cur_q;
    logic [15:0]      cnt_q, cnt_d, evc_q;
    logic             exc_q, aexc_q, val_q, pend_q;
    logic             empty, full, push;
    logic [IDX_W-1:0] head;
    logic [31:0]      fadd_res;
    logic             fadd_exc;

    assign empty = wr_q == rd_q;
    assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    // once a close is seen, new events wait for the next step
    assign spike_ready = !full && !pend_q
                         && state_q != DRAIN && state_q != PUBLISH;
    assign push  = spike_valid && spike_ready;
    assign head  = fifo_q[rd_q[PW-1:0]];
    assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    assign current_out   = cur_q;
    assign current_valid = val_q;
    assign event_count   = evc_q;
    assign acc_exc       = aexc_q;
    assign busy          = state_q != IDLE;

    Addition_Subtraction u_fadd (
        .a_operand  (acc_q),
        .b_operand  (op_q),
        .AddBar_Sub (1'b0),
        .Exception  (fadd_exc),
        .result     (fadd_res)
    );

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q[PW-1:0]] <= spike_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_SYN; i++) w_q[i] <= 32'd0;
            wr_q    <= '0;
            rd_q    <= '0;
            acc_q   <= 32'd0;
            op_q    <= 32'd0;
            cur_q   <= 32'd0;
            cnt_q   <= 16'd0;
            evc_q   <= 16'd0;
            exc_q   <= 1'b0;
            aexc_q  <= 1'b0;
            val_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            val_q <= 1'b0;
            if (w_we) w_q[w_addr] <= w_data;
            if (push) wr_q <= wr_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (close_step) begin
                        pend_q  <= 1'b1;
                        state_q <= DRAIN;
                    end else if (!empty) begin
                        state_q <= POP;
                    end
                end
                POP: begin
                    op_q    <= w_q[head];
                    rd_q    <= rd_q + 1'b1;
                    if (close_step) pend_q <= 1'b1;
                    state_q <= ACC;
                end
                ACC: begin
                    acc_q <= fadd_res;
                    cnt_q <= cnt_d;
                    exc_q <= exc_q | fadd_exc;
                    if (pend_q || close_step) begin
                        pend_q  <= 1'b1;
                        state_q <= DRAIN;
                    end else if (!empty) begin
                        state_q <= POP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!empty) begin
                        state_q <= POP;
                    end else begin
                        pend_q  <= 1'b0;
                        state_q <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    cur_q   <= acc_q;
                    evc_q   <= cnt_q;
                    aexc_q  <= exc_q;
                    val_q   <= 1'b1;
                    acc_q   <= 32'd0;
                    cnt_q   <= 16'd0;
                    exc_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
